// File: rtl/cla_seq_adder_ctrl_pkg.sv
// ============================================================================
// Module   : cla_seq_adder_ctrl_pkg
// Brief    : Shared state encoding and nibble constants for the sequential
//            CLA add/subtract controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_seq_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_if.sv
// ============================================================================
// Module   : cla_seq_adder_ctrl_if
// Brief    : Request/result bundle of the sequential CLA add/subtract unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  ready, busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output ready, busy, done, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// ============================================================================
// Module   : cla4bit
// Brief    : 4-bit carry-lookahead adder exposing per-bit carry-ins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla4bit (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       cin,
  output logic      [3:0] s,
  output logic      [3:0] c,
  output logic            cout
);
  logic [3:0] g;
  logic [3:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] is the carry into bit i, so c[3] feeds the nibble MSB.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;
endmodule

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module   : cla_seq_adder_ctrl
// Brief    : WIDTH-bit add/subtract computed one nibble per cycle, LSB first,
//            on a single shared 4-bit CLA with a registered carry chain.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_seq_adder_ctrl
  import cla_seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  cla_seq_adder_ctrl_if.slave  bus
);
  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0] nib_a, nib_b, cla_s, cla_c;
  logic       cla_cout;
  logic       unused_low_carries;

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign unused_low_carries = ^cla_c[2:0];

  cla4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (cla_s),
    .c    (cla_c),
    .cout (cla_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1, so the invert and forced carry happen here.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = cla_s;
        carry_d = cla_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = cla_cout;
          ovf_d   = cla_c[3] ^ cla_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// ============================================================================
// Module   : tb_cla_seq_adder_ctrl
// Brief    : Self-checking bench: directed vector table, random operations
//            against an arithmetic reference, and multi-cycle corner sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_seq_adder_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference from plain integer arithmetic on the operand values.
  function automatic void model(input logic s, input logic c,
                                input logic [15:0] aa, input logic [15:0] bb,
                                output logic [15:0] rs, output logic rc, output logic ro);
    int sa, sb, sres;
    int unsigned ures;
    sa = $signed(aa);
    sb = $signed(bb);
    if (!s) begin
      sres = sa + sb + int'(c);
      ures = 32'(aa) + 32'(bb) + 32'(c);
      rc   = (ures >= 32'd65536);
    end else begin
      sres = sa - sb;
      rc   = (aa >= bb);
    end
    rs = sres[15:0];
    ro = (sres > 32767) || (sres < -32768);
  endfunction

  // Issues one operation from IDLE; returns at (edge after done)+1.
  task automatic run_op(input logic s, input logic c, input logic [15:0] aa, input logic [15:0] bb,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat, output logic done_after, output logic ready_after);
    bus.sub = s; bus.cin = c; bus.a = aa; bus.b = bb; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = bus.sum; rc = bus.cout; ro = bus.overflow;
    @(posedge clk); #1;
    done_after  = bus.done;
    ready_after = bus.ready;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] rs, m_sum;
    logic        rc, ro, m_c, m_o, d_after, r_after;
    logic [15:0] ra, rb;
    logic        rsub, rcin;
    int          lat, cyc, done1, done2;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_done",  32'(bus.done),  32'd0);
    check("reset_sum",   32'(bus.sum),   32'd0);
    check("reset_cout",  32'(bus.cout),  32'd0);
    check("reset_ovf",   32'(bus.overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, rs, rc, ro, lat, d_after, r_after);
      check($sformatf("vec%0d_sum", i),  32'(rs), 32'(vecs[i].e_sum));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].e_cout));
      check($sformatf("vec%0d_ovf", i),  32'(ro), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_done_width", i), 32'(d_after), 32'd0);
      check($sformatf("vec%0d_ready_back", i), 32'(r_after), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rcin = 1'($urandom);
      if (i < 4) begin ra = 16'h8000; rb = (i < 2) ? 16'h8000 : 16'h7FFF; end
      model(rsub, rcin, ra, rb, m_sum, m_c, m_o);
      run_op(rsub, rcin, ra, rb, rs, rc, ro, lat, d_after, r_after);
      check($sformatf("rnd%0d_sum", i),  32'(rs), 32'(m_sum));
      check($sformatf("rnd%0d_cout", i), 32'(rc), 32'(m_c));
      check($sformatf("rnd%0d_ovf", i),  32'(ro), 32'(m_o));
    end

    // start held through RUN/DONE with changing operands, then a second op.
    bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; done1 = -1; done2 = -1;
    while (done2 < 0 && cyc < 40) begin
      if (done1 < 0) begin
        check($sformatf("ign_ready_c%0d", cyc), 32'(bus.ready), 32'd0);
        if (bus.done) begin
          done1 = cyc;
          check("ign_sum", 32'(bus.sum), 32'h3333);
          bus.sub = 1'b1; bus.cin = 1'b1; bus.a = 16'h0100; bus.b = 16'h0200;
        end else begin
          bus.a = 16'($urandom); bus.b = 16'($urandom);
          bus.sub = 1'($urandom); bus.cin = 1'($urandom);
        end
      end else if (bus.done) begin
        done2 = cyc;
      end
      if (done2 < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    check("b2b_first_done", 32'(done1), 32'd4);
    check("b2b_period", 32'(done2 - done1), 32'd6);
    check("b2b_sum",  32'(bus.sum),  32'hFF00);
    check("b2b_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset between edges, after nibble 1 has been written.
    bus.sub = 1'b0; bus.cin = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_cout",  32'(bus.cout),  32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 16'h0FFF, 16'h7000, rs, rc, ro, lat, d_after, r_after);
    check("post_rst_sum",  32'(rs), 32'h8000);
    check("post_rst_cout", 32'(rc), 32'd0);
    check("post_rst_ovf",  32'(ro), 32'd1);
    check("post_rst_latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
